// File: rtl/stumps_pkg.sv
// Shared definitions for the STUMPS BIST controller: FSM encoding and default
// MISR polynomial / golden signature.
package stumps_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SHIFT   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } state_e;

    // x^8 + x^4 + x^3 + x^2 + 1, leading term implied
    localparam logic [7:0] DEF_POLY   = 8'h1D;
    localparam logic [7:0] DEF_GOLDEN = 8'h00;

endpackage

// File: rtl/stumps_misr.sv
// Multiple-input signature register: Galois-style shift with polynomial
// feedback, XORing one scan-chain output into each stage.
module stumps_misr
    import stumps_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Clear wins over compaction so a new session always starts from zero
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = (q_q << 1) ^ (q_q[WIDTH-1] ? POLY : '0) ^ d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/stumps_misr_ctrl.sv
// STUMPS self-test controller: sequences scan shift/capture over NUM_PAT
// patterns, compacts chain outputs into a MISR and compares to GOLDEN.
module stumps_misr_ctrl
    import stumps_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      CHAIN_LEN = 16,
    parameter int unsigned      NUM_PAT   = 32,
    parameter logic [WIDTH-1:0] POLY      = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] GOLDEN    = WIDTH'(DEF_GOLDEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] SO,
    output logic             TC,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam int unsigned SH_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int unsigned PAT_W = $clog2(NUM_PAT + 1);

    localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(CHAIN_LEN - 1);
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PAT);

    state_e           state_q;
    logic [SH_W-1:0]  shift_q;
    logic [PAT_W-1:0] pat_q;
    logic             tc_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic             launch;
    logic             misr_clr;
    logic             misr_en;
    logic [WIDTH-1:0] sig_step;

    // Phase 0 only loads the chains, so compaction starts with phase 1
    always_comb begin
        launch   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        misr_clr = launch;
        misr_en  = (state_q == ST_SHIFT) && (pat_q != '0);
        sig_step = (signature << 1) ^ (signature[WIDTH-1] ? POLY : '0) ^ SO;
    end

    // Outputs are registered alongside the state they decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            pat_q   <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        state_q <= ST_SHIFT;
                        shift_q <= '0;
                        pat_q   <= '0;
                        tc_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (shift_q == SH_LAST) begin
                        shift_q <= '0;
                        tc_q    <= 1'b0;
                        if (pat_q == PAT_LAST) begin
                            // Final unload: compare the value the MISR takes on this edge
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (sig_step == GOLDEN);
                        end else begin
                            state_q <= ST_CAPTURE;
                        end
                    end else begin
                        shift_q <= shift_q + SH_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    state_q <= ST_SHIFT;
                    pat_q   <= pat_q + PAT_W'(1);
                    shift_q <= '0;
                    tc_q    <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    tc_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    stumps_misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (misr_clr),
        .en  (misr_en),
        .d   (SO),
        .q   (signature)
    );

    assign TC   = tc_q;
    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_stumps_misr_ctrl.sv
// Bench for stumps_misr_ctrl: three parameterisations driven with directed and
// random chain data, checked against a cycle-level session model.
module tb_stumps_misr_ctrl;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_s [NDUT];
    logic [7:0] so_s    [NDUT];
    logic       tc_s    [NDUT];
    logic       busy_s  [NDUT];
    logic       done_s  [NDUT];
    logic       pass_s  [NDUT];
    logic [7:0] sig_s   [NDUT];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stumps_misr_ctrl u_a (
        .clk(clk), .rst(rst), .start(start_s[0]), .SO(so_s[0]), .TC(tc_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .signature(sig_s[0])
    );

    stumps_misr_ctrl #(.CHAIN_LEN(4), .NUM_PAT(2)) u_b (
        .clk(clk), .rst(rst), .start(start_s[1]), .SO(so_s[1]), .TC(tc_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .signature(sig_s[1])
    );

    stumps_misr_ctrl #(.CHAIN_LEN(1), .NUM_PAT(1)) u_c (
        .clk(clk), .rst(rst), .start(start_s[2]), .SO(so_s[2]), .TC(tc_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .signature(sig_s[2])
    );

    function automatic int cl_of(input int k);
        case (k)
            0:       return 16;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int np_of(input int k);
        case (k)
            0:       return 32;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    // Signature times x modulo x^8+x^4+x^3+x^2+1, plus the new chain bits
    function automatic logic [7:0] misr_model(input logic [7:0] s, input logic [7:0] d);
        logic [8:0] t;
        t = {s, 1'b0};
        if (t[8]) t = t ^ 9'h11D;
        return t[7:0] ^ d;
    endfunction

    function automatic logic [7:0] so_pick(input int mode, input int p, input int s,
                                           input int cl, input int np);
        case (mode)
            1:       return 8'($urandom);
            2:       return (p == np && s == cl - 2) ? 8'h80 : 8'h00;
            3:       return (p == 0) ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input int k, input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL dut%0d %s observed=%0h expected=%0h", k, tag, obs, exp);
        end
    endtask

    // One session: start, then every cycle to the first DONE cycle, then one hold cycle
    task automatic run_session(input int k, input int mode, input int hold);
        int         cl;
        int         np;
        int         c;
        logic [7:0] so;
        logic [7:0] sig_m;
        cl    = cl_of(k);
        np    = np_of(k);
        c     = 0;
        sig_m = 8'h00;
        @(negedge clk);
        start_s[k] = 1'b1;
        so_s[k]    = 8'h00;
        for (int p = 0; p <= np; p++) begin
            for (int s = 0; s < cl; s++) begin
                @(negedge clk);
                c++;
                start_s[k] = (c < hold);
                so         = so_pick(mode, p, s, cl, np);
                so_s[k]    = so;
                chk(k, "tc_shift",   32'(tc_s[k]),   32'd1);
                chk(k, "busy_shift", 32'(busy_s[k]), 32'd1);
                chk(k, "done_shift", 32'(done_s[k]), 32'd0);
                chk(k, "pass_shift", 32'(pass_s[k]), 32'd0);
                if (c == 1) chk(k, "sig_cleared", 32'(sig_s[k]), 32'd0);
                if (p > 0) sig_m = misr_model(sig_m, so);
            end
            if (p < np) begin
                @(negedge clk);
                c++;
                start_s[k] = (c < hold);
                so_s[k]    = 8'($urandom);
                chk(k, "tc_capture",   32'(tc_s[k]),   32'd0);
                chk(k, "busy_capture", 32'(busy_s[k]), 32'd1);
                chk(k, "done_capture", 32'(done_s[k]), 32'd0);
            end
        end
        @(negedge clk);
        start_s[k] = 1'b0;
        so_s[k]    = 8'($urandom);
        chk(k, "done_final", 32'(done_s[k]), 32'd1);
        chk(k, "busy_final", 32'(busy_s[k]), 32'd0);
        chk(k, "tc_final",   32'(tc_s[k]),   32'd0);
        chk(k, "signature",  32'(sig_s[k]),  32'(sig_m));
        chk(k, "pass",       32'(pass_s[k]), 32'(sig_m == 8'h00));
        @(negedge clk);
        chk(k, "done_hold", 32'(done_s[k]), 32'd1);
        chk(k, "sig_hold",  32'(sig_s[k]),  32'(sig_m));
        chk(k, "pass_hold", 32'(pass_s[k]), 32'(sig_m == 8'h00));
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            start_s[k] = 1'b0;
            so_s[k]    = 8'h00;
        end
        #2;
        for (int k = 0; k < NDUT; k++) begin
            chk(k, "rst_tc",   32'(tc_s[k]),   32'd0);
            chk(k, "rst_busy", 32'(busy_s[k]), 32'd0);
            chk(k, "rst_done", 32'(done_s[k]), 32'd0);
            chk(k, "rst_pass", 32'(pass_s[k]), 32'd0);
            chk(k, "rst_sig",  32'(sig_s[k]),  32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Zero data with GOLDEN=0: exact TC timing and pass on all three
        run_session(1, 0, 0);
        run_session(2, 0, 0);
        run_session(0, 0, 0);

        // Single bit injected two cycles before the end shifts into the feedback
        run_session(0, 2, 0);
        // Phase-0 data must never reach the signature
        run_session(0, 3, 0);
        run_session(1, 3, 0);

        // Random chain data, back-to-back sessions restarted from DONE
        run_session(0, 1, 0);
        run_session(1, 1, 0);
        run_session(1, 1, 0);
        run_session(2, 1, 0);
        run_session(2, 1, 0);

        // start held for 20 cycles mid-session must not restart it
        run_session(0, 1, 20);

        // Reset in the middle of a shift phase
        @(negedge clk);
        start_s[0] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start_s[0] = 1'b0;
            so_s[0]    = 8'($urandom);
        end
        rst = 1'b0;
        #1;
        chk(0, "midrst_tc",   32'(tc_s[0]),   32'd0);
        chk(0, "midrst_busy", 32'(busy_s[0]), 32'd0);
        chk(0, "midrst_done", 32'(done_s[0]), 32'd0);
        chk(0, "midrst_pass", 32'(pass_s[0]), 32'd0);
        chk(0, "midrst_sig",  32'(sig_s[0]),  32'd0);
        @(negedge clk);
        rst     = 1'b1;
        so_s[0] = 8'h00;
        @(negedge clk);
        chk(0, "postrst_idle_busy", 32'(busy_s[0]), 32'd0);
        chk(0, "postrst_idle_tc",   32'(tc_s[0]),   32'd0);
        run_session(0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stumps_misr_ctrl.md
STUMPS_MISR_CTRL -- requirements
Module: stumps_misr_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: number of parallel scan chains and the MISR width.
REQ-002 Parameter CHAIN_LEN, default 16: scan cells per chain, which is the number of shift cycles per pattern.
REQ-003 Parameter NUM_PAT, default 32: number of test patterns per session.
REQ-004 Parameter POLY, default 8'h1D: MISR feedback polynomial taps, x^8+x^4+x^3+x^2+1, excluding the x^WIDTH term.
REQ-005 Parameter GOLDEN, default 8'h00: expected fault-free signature.
REQ-006 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-007 Port rst, input, 1 bit: reset; asynchronous, active-low.
REQ-008 Port start, input, 1 bit: request to begin a BIST session; sampled on the rising edge.
REQ-009 Port SO, input, WIDTH bits: serial outputs of the scan-register chains, one bit per chain.
REQ-010 Port TC, output, 1 bit: test control to the scan registers; 1 = shift, 0 = functional capture or hold.
REQ-011 Port busy, output, 1 bit: high while a session is in progress.
REQ-012 Port done, output, 1 bit: high while the session is complete and the result is valid.
REQ-013 Port pass, output, 1 bit: signature compare result; valid only while done is high.
REQ-014 Port signature, output, WIDTH bits: current MISR contents.

Function
REQ-015 The FSM SHALL have four states: IDLE, SHIFT, CAPTURE and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL clear the MISR to 0, clear the shift and pattern counters, and enter SHIFT on the next cycle.
REQ-017 In SHIFT, TC SHALL be 1 for exactly CHAIN_LEN consecutive cycles, counted by a shift counter that runs from 0 to CHAIN_LEN-1.
REQ-018 Shift phases SHALL be numbered 0 to NUM_PAT by the pattern counter.
REQ-019 Shift phase 0 is load-only: the MISR SHALL hold its value during it.
REQ-020 In phases 1 to NUM_PAT, the MISR SHALL compact on every shift cycle.
REQ-021 MISR update rule: sig_next = {sig[WIDTH-2:0],1'b0} XOR (sig[WIDTH-1] ? POLY : 0) XOR SO.
REQ-022 On the last shift cycle of phase p < NUM_PAT, the FSM SHALL enter CAPTURE.
REQ-023 CAPTURE SHALL last exactly 1 cycle with TC=0 and the MISR holding; the pattern counter increments and the FSM returns to SHIFT.
REQ-024 On the last shift cycle of phase NUM_PAT, the FSM SHALL enter DONE; no capture follows the final unload.
REQ-025 Session length SHALL be (NUM_PAT+1)*CHAIN_LEN + NUM_PAT cycles from the first SHIFT cycle to the first DONE cycle.
REQ-026 busy SHALL be 1 exactly in SHIFT and CAPTURE.
REQ-027 done SHALL be 1 exactly in DONE.
REQ-028 TC SHALL be 0 in IDLE, CAPTURE and DONE.
REQ-029 pass SHALL equal (signature == GOLDEN) while in DONE, and SHALL be 0 otherwise.
REQ-030 The signature and pass SHALL be held in DONE until a new start.
REQ-031 start SHALL be ignored while busy=1.
REQ-032 start held high for several cycles SHALL begin only one session.
REQ-033 The counters SHALL be sized ceil(log2(CHAIN_LEN)) and ceil(log2(NUM_PAT+1)) bits and SHALL never wrap within a session.
REQ-034 CHAIN_LEN=1 and NUM_PAT=1 SHALL be legal and SHALL follow the same rules.

Reset
REQ-035 While rst=0, the block SHALL immediately force: state IDLE, signature 0, counters 0, and TC, busy, done, pass all 0.
REQ-036 Reset asserted mid-session SHALL abort the session with no residual state; after rst rises, the first start SHALL begin a full session.

Structure
REQ-037 The state encoding and the default POLY and GOLDEN constants SHALL reside in the shared package stumps_pkg.
REQ-038 The MISR register and update logic SHALL be the sub-module stumps_misr, with ports clk, rst, clr, en, d[WIDTH], q[WIDTH].
REQ-039 The FSM and counters SHALL reside in stumps_misr_ctrl.

Verification
REQ-040 Reset value: pulse rst low mid-SHIFT -> TC, busy, done, pass and signature read 0 within the same cycle; state IDLE.
REQ-041 Timing: CHAIN_LEN=4, NUM_PAT=2, SO=0, start pulse -> TC pattern 1111 0 1111 0 1111 over 14 cycles; done=1 on cycle 15; pass=1 with GOLDEN=0.
REQ-042 Polynomial: default parameters; SO=8'h80 on the second-to-last shift cycle of phase NUM_PAT, else 0 -> signature=8'h1D in DONE; pass=0.
REQ-043 Load masking: SO=8'hFF during phase 0 only, else 0 -> signature=8'h00; pass=1.
REQ-044 Start handling: start held high for 20 cycles mid-session -> no restart and the session length is unchanged; start in DONE -> signature clears and a new session begins.
